// File: rtl/reg_read_port.sv
// Two-operand register-bank read port with a 2-entry (head + skid) response buffer.
// Optional macro REG_READ_BYPASS_EN forwards same-edge bank writes (ALUBus/regEnable) into captured operands.
module reg_read_port (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] r0,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    input  logic [15:0] r3,
    input  logic [15:0] r4,
    input  logic [15:0] r5,
    input  logic [15:0] r6,
    input  logic [15:0] r7,
    input  logic [15:0] r8,
    input  logic [15:0] r9,
    input  logic [15:0] r10,
    input  logic [15:0] r11,
    input  logic [15:0] r12,
    input  logic [15:0] r13,
    input  logic [15:0] r14,
    input  logic [15:0] r15,
    input  logic [15:0] ALUBus,
    input  logic [15:0] regEnable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  rsrc_addr,
    input  logic [3:0]  rdest_addr,
    output logic [15:0] rsrc_data,
    output logic [15:0] rdest_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rd_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bufState_t;

    bufState_t   state_q, state_d;
    logic [15:0] headSrc_q, headSrc_d;
    logic [15:0] headDst_q, headDst_d;
    logic [15:0] skidSrc_q, skidSrc_d;
    logic [15:0] skidDst_q, skidDst_d;
    logic        reqReady_q, reqReady_d;
    logic [15:0] rdCount_q, rdCount_d;

    logic [15:0] bank [16];
    logic [15:0] srcVal;
    logic [15:0] dstVal;
    logic        accept;
    logic        xfer;

    assign bank[0]  = r0;
    assign bank[1]  = r1;
    assign bank[2]  = r2;
    assign bank[3]  = r3;
    assign bank[4]  = r4;
    assign bank[5]  = r5;
    assign bank[6]  = r6;
    assign bank[7]  = r7;
    assign bank[8]  = r8;
    assign bank[9]  = r9;
    assign bank[10] = r10;
    assign bank[11] = r11;
    assign bank[12] = r12;
    assign bank[13] = r13;
    assign bank[14] = r14;
    assign bank[15] = r15;

`ifdef REG_READ_BYPASS_EN
    // A write landing on the same edge as the accept wins over the stale bank value.
    always_comb begin
        srcVal = regEnable[rsrc_addr]  ? ALUBus : bank[rsrc_addr];
        dstVal = regEnable[rdest_addr] ? ALUBus : bank[rdest_addr];
    end
`else
    logic unusedWritePort;
    assign unusedWritePort = ^{ALUBus, regEnable};

    always_comb begin
        srcVal = bank[rsrc_addr];
        dstVal = bank[rdest_addr];
    end
`endif

    assign accept = req_valid & reqReady_q;
    assign xfer   = (state_q != EMPTY) & rsp_ready;

    always_comb begin
        state_d   = state_q;
        headSrc_d = headSrc_q;
        headDst_d = headDst_q;
        skidSrc_d = skidSrc_q;
        skidDst_d = skidDst_q;
        rdCount_d = rdCount_q;
        if (accept) begin
            rdCount_d = rdCount_q + 16'd1;
        end
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    headSrc_d = srcVal;
                    headDst_d = dstVal;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    headSrc_d = srcVal;
                    headDst_d = dstVal;
                end else if (accept) begin
                    state_d   = FULL;
                    skidSrc_d = srcVal;
                    skidDst_d = dstVal;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // req_ready is low here, so only a transfer can happen.
                if (xfer) begin
                    state_d   = ONE;
                    headSrc_d = skidSrc_q;
                    headDst_d = skidDst_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        reqReady_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            headSrc_q  <= 16'h0000;
            headDst_q  <= 16'h0000;
            skidSrc_q  <= 16'h0000;
            skidDst_q  <= 16'h0000;
            reqReady_q <= 1'b1;
            rdCount_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            headSrc_q  <= headSrc_d;
            headDst_q  <= headDst_d;
            skidSrc_q  <= skidSrc_d;
            skidDst_q  <= skidDst_d;
            reqReady_q <= reqReady_d;
            rdCount_q  <= rdCount_d;
        end
    end

    assign req_ready  = reqReady_q;
    assign rsp_valid  = (state_q != EMPTY);
    assign rsrc_data  = headSrc_q;
    assign rdest_data = headDst_q;
    assign rd_count   = rdCount_q;

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: directed scenarios plus randomized traffic
// compared against a queue-based model of the response buffer.
module tb_reg_read_port;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] d;
    } rsp_t;

    logic        clk;
    logic        reset;
    logic [15:0] regs [16];
    logic [15:0] ALUBus;
    logic [15:0] regEnable;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  rsrc_addr;
    logic [3:0]  rdest_addr;
    logic [15:0] rsrc_data;
    logic [15:0] rdest_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rd_count;

    rsp_t        q[$];
    logic [15:0] mCount;
    int          nCompared;
    int          nMismatched;

    reg_read_port dut (
        .clk        (clk),
        .reset      (reset),
        .r0         (regs[0]),
        .r1         (regs[1]),
        .r2         (regs[2]),
        .r3         (regs[3]),
        .r4         (regs[4]),
        .r5         (regs[5]),
        .r6         (regs[6]),
        .r7         (regs[7]),
        .r8         (regs[8]),
        .r9         (regs[9]),
        .r10        (regs[10]),
        .r11        (regs[11]),
        .r12        (regs[12]),
        .r13        (regs[13]),
        .r14        (regs[14]),
        .r15        (regs[15]),
        .ALUBus     (ALUBus),
        .regEnable  (regEnable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .rsrc_addr  (rsrc_addr),
        .rdest_addr (rdest_addr),
        .rsrc_data  (rsrc_data),
        .rdest_data (rdest_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rd_count   (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] opVal(input logic [3:0] a);
`ifdef REG_READ_BYPASS_EN
        if (regEnable[a]) return ALUBus;
`endif
        return regs[a];
    endfunction

    // One clock: predict from current inputs, step the edge, update the model; outputs sampled 1 time unit later.
    task automatic cycle();
        bit   acc;
        bit   xf;
        rsp_t e;
        acc = req_valid && (q.size() < 2);
        xf  = (q.size() > 0) && rsp_ready;
        e.s = opVal(rsrc_addr);
        e.d = opVal(rdest_addr);
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            mCount = 16'h0000;
        end else begin
            if (xf) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                mCount = mCount + 16'd1;
            end
        end
    endtask

    task automatic doReset(input int edges);
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < edges; i++) cycle();
        reset = 1'b0;
    endtask

    task automatic randomizeInputs();
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        ALUBus     = 16'($urandom);
        regEnable  = 16'($urandom);
        rsrc_addr  = 4'($urandom);
        rdest_addr = 4'($urandom);
    endtask

    task automatic test_reset();
        doReset(2);
        nCompared += 4;
        if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
        if (rd_count !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_rd_count: got %h want 0000", rd_count); end
        if ({rsrc_data, rdest_data} !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_data: got %h/%h want 0000/0000", rsrc_data, rdest_data); end
    endtask

    task automatic test_basic_read();
        regEnable  = 16'h0000;
        regs[3]    = 16'h1234;
        regs[12]   = 16'hABCD;
        rsrc_addr  = 4'd3;
        rdest_addr = 4'd12;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        cycle();
        req_valid = 1'b0;
        nCompared += 4;
        if (rsp_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_rsp_valid: got %b want 1", rsp_valid); end
        if (rsrc_data !== 16'h1234) begin nMismatched++; $display("[TB] FAIL basic_rsrc: got %h want 1234", rsrc_data); end
        if (rdest_data !== 16'hABCD) begin nMismatched++; $display("[TB] FAIL basic_rdest: got %h want abcd", rdest_data); end
        if (rd_count !== 16'd1) begin nMismatched++; $display("[TB] FAIL basic_rd_count: got %h want 0001", rd_count); end
        cycle();
    endtask

    task automatic test_write_collision();
        logic [15:0] want;
`ifdef REG_READ_BYPASS_EN
        want = 16'hFFFF;
`else
        want = 16'h0000;
`endif
        regs[0]    = 16'h0000;
        ALUBus     = 16'hFFFF;
        regEnable  = 16'h0001;
        rsrc_addr  = 4'd0;
        rdest_addr = 4'd0;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        cycle();
        req_valid = 1'b0;
        regEnable = 16'h0000;
        nCompared += 2;
        if (rsrc_data !== want) begin nMismatched++; $display("[TB] FAIL collision_rsrc: got %h want %h", rsrc_data, want); end
        if (rdest_data !== want) begin nMismatched++; $display("[TB] FAIL collision_rdest: got %h want %h", rdest_data, want); end
        cycle();
    endtask

    task automatic test_backpressure();
        doReset(1);
        regEnable = 16'h0000;
        for (int i = 0; i < 16; i++) regs[i] = 16'(i) * 16'h0101;
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        rsrc_addr  = 4'd1;
        rdest_addr = 4'd2;
        cycle();
        nCompared += 2;
        if (req_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_one_ready: got %b want 1", req_ready); end
        if (rsrc_data !== 16'h0101) begin nMismatched++; $display("[TB] FAIL bp_one_rsrc: got %h want 0101", rsrc_data); end
        rsrc_addr  = 4'd3;
        rdest_addr = 4'd4;
        cycle();
        nCompared += 1;
        if (req_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_full_ready: got %b want 0", req_ready); end
        rsrc_addr  = 4'd5;
        rdest_addr = 4'd6;
        cycle();
        nCompared += 3;
        if (req_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_stall_ready: got %b want 0", req_ready); end
        if (rd_count !== 16'd2) begin nMismatched++; $display("[TB] FAIL bp_stall_count: got %h want 0002", rd_count); end
        if ({rsrc_data, rdest_data} !== {16'h0101, 16'h0202}) begin nMismatched++; $display("[TB] FAIL bp_hold: got %h/%h want 0101/0202", rsrc_data, rdest_data); end
        rsp_ready = 1'b1;
        cycle();
        nCompared += 2;
        if ({rsrc_data, rdest_data} !== {16'h0303, 16'h0404}) begin nMismatched++; $display("[TB] FAIL bp_second: got %h/%h want 0303/0404", rsrc_data, rdest_data); end
        if (req_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_reopen: got %b want 1", req_ready); end
        cycle();
        req_valid = 1'b0;
        nCompared += 2;
        if ({rsrc_data, rdest_data} !== {16'h0505, 16'h0606}) begin nMismatched++; $display("[TB] FAIL bp_third: got %h/%h want 0505/0606", rsrc_data, rdest_data); end
        if (rd_count !== 16'd3) begin nMismatched++; $display("[TB] FAIL bp_count: got %h want 0003", rd_count); end
        cycle();
        nCompared += 1;
        if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        randomizeInputs();
        cycle();
        randomizeInputs();
        cycle();
        nCompared += 1;
        if (req_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_full: got %b want 0", req_ready); end
        reset     = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        reset = 1'b0;
        nCompared += 4;
        if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_req_ready: got %b want 1", req_ready); end
        if (rd_count !== 16'h0000) begin nMismatched++; $display("[TB] FAIL mid_rd_count: got %h want 0000", rd_count); end
        if ({rsrc_data, rdest_data} !== 32'h0) begin nMismatched++; $display("[TB] FAIL mid_data: got %h/%h want 0000/0000", rsrc_data, rdest_data); end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            nCompared++;
            if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_stale: cycle %0d got rsp_valid %b want 0", i, rsp_valid); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            randomizeInputs();
            req_valid = 1'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            nCompared += 3;
            if (rsp_valid !== (q.size() > 0)) begin nMismatched++; $display("[TB] FAIL rand_rsp_valid: cycle %0d got %b want %b", i, rsp_valid, q.size() > 0); end
            if (req_ready !== (q.size() < 2)) begin nMismatched++; $display("[TB] FAIL rand_req_ready: cycle %0d got %b want %b", i, req_ready, q.size() < 2); end
            if (rd_count !== mCount) begin nMismatched++; $display("[TB] FAIL rand_rd_count: cycle %0d got %h want %h", i, rd_count, mCount); end
            if (q.size() > 0) begin
                nCompared++;
                if ({rsrc_data, rdest_data} !== {q[0].s, q[0].d}) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_data: cycle %0d got %h/%h want %h/%h", i, rsrc_data, rdest_data, q[0].s, q[0].d);
                end
            end
        end
    endtask

    task automatic test_wrap();
        doReset(1);
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            regs[$urandom_range(0, 15)] = 16'($urandom);
            ALUBus     = 16'($urandom);
            regEnable  = 16'($urandom);
            rsrc_addr  = 4'($urandom);
            rdest_addr = 4'($urandom);
            cycle();
            nCompared++;
            if (rsp_valid !== 1'b1 || q.size() != 1 || {rsrc_data, rdest_data} !== {q[0].s, q[0].d}) begin
                nMismatched++;
                if (nMismatched < 20) $display("[TB] FAIL wrap_stream: accept %0d got v=%b %h/%h want v=1 %h/%h", i, rsp_valid, rsrc_data, rdest_data, q[0].s, q[0].d);
            end
        end
        req_valid = 1'b0;
        nCompared++;
        if (rd_count !== 16'h0000) begin nMismatched++; $display("[TB] FAIL wrap_count: got %h want 0000", rd_count); end
        cycle();
        nCompared++;
        if (rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_drain: got %b want 0", rsp_valid); end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        mCount      = 16'h0000;
        reset       = 1'b1;
        req_valid   = 1'b0;
        rsp_ready   = 1'b0;
        ALUBus      = 16'h0000;
        regEnable   = 16'h0000;
        rsrc_addr   = 4'd0;
        rdest_addr  = 4'd0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        #1;
        test_reset();
        test_basic_read();
        test_write_collision();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
